axi_mon_recovery_ctrl: RTL and testbench
========================================

# axi_mon_recovery_ctrl

Recovery sequencer for the AXI monitor slave port. On a timeout pulse from the monitor it walks the downstream slave through isolate, drain, reset and release, in that order, before returning the port to service. It sits beside the monitor and drives the isolation gate, the monitor's flush/error-response mode and the downstream slave's reset request. It exposes sticky status (IRQ, drain failure, recovery count) for the regbus status registers.

## Interface
Parameters:
- MaxUniqIds, 1, unique IDs tracked by the monitor
- MaxTxnsPerId, 2, outstanding transactions per ID
- CntWidth, 10, width of the drain deadline counter
- DrainMax, 1000, drain deadline in cycles; must be < 2^CntWidth
- RstHoldCycles, 16, cycles `slv_rst_no` is held low; must be >= 1
- TxnCntWidth, $clog2(MaxUniqIds*MaxTxnsPerId+1), derived; do not override

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- enable_i  in  1  arms recovery; sampled only in IDLE
- timeout_i  in  1  single-cycle timeout pulse from the monitor
- isolated_i  in  1  isolation gate reports it is fully isolated (high) or fully open (low)
- outstanding_i  in  TxnCntWidth  transactions still pending in the monitor
- irq_clear_i  in  1  clears `irq_o`
- isolate_o  out  1  request to gate the slave port
- flush_o  out  1  monitor answers all pending transactions with SLVERR
- slv_rst_no  out  1  active-low reset request to the downstream slave
- irq_o  out  1  sticky recovery interrupt
- drain_fail_o  out  1  sticky: a drain hit the DrainMax deadline
- recover_cnt_o  out  8  completed recoveries, saturating at 255
- state_o  out  3  current state encoding

## Operation
- State machine: IDLE=0, ISOLATE=1, DRAIN=2, RESET=3, RELEASE=4. Encodings 5–7 are unreachable and decode as IDLE.
- IDLE:
  - Outputs: isolate_o=0, flush_o=0, slv_rst_no=1.
  - enable_i && timeout_i moves to ISOLATE and sets irq_o.
  - timeout_i with enable_i=0 is ignored.
- ISOLATE:
  - isolate_o=1.
  - isolated_i=1 moves to DRAIN and clears the drain counter.
  - There is no deadline in this state.
- DRAIN:
  - isolate_o=1, flush_o=1.
  - The drain counter increments each cycle and saturates.
  - outstanding_i==0 moves to RESET.
  - Otherwise, the counter reaching DrainMax-1 sets drain_fail_o and moves to RESET.
  - If both conditions hold in the same cycle, the zero-outstanding exit wins and drain_fail_o is not set.
- RESET:
  - isolate_o=1, flush_o=0, slv_rst_no=0.
  - The hold counter loads RstHoldCycles-1 on entry and counts down.
  - At 0 the FSM moves to RELEASE.
- RELEASE:
  - isolate_o=0, slv_rst_no=1.
  - isolated_i=0 moves to IDLE and increments recover_cnt_o (saturating).
- timeout_i outside IDLE is ignored; events are neither queued nor counted.
- enable_i deasserted mid-sequence does not abort; the sequence completes.
- irq_o:
  - Set on the IDLE→ISOLATE transition.
  - Cleared by irq_clear_i.
  - Set wins over a simultaneous clear.
- drain_fail_o is cleared only by reset.
- Reset mid-operation returns immediately to IDLE with every output at its reset value. The downstream reset request is released asynchronously.

## Timing
- Reset values: state_o=0, isolate_o=0, flush_o=0, slv_rst_no=1, irq_o=0, drain_fail_o=0, recover_cnt_o=0.
- All outputs are registered or decoded directly from the state register (Moore); there is no combinational input→output path.
- timeout_i at cycle t gives state ISOLATE, isolate_o=1 and irq_o=1 at t+1.
- isolated_i=1 at cycle t (in ISOLATE) gives flush_o=1 at t+1.
- outstanding_i==0 at cycle t (in DRAIN) gives slv_rst_no=0 at t+1, held for exactly RstHoldCycles cycles.
- Drain timeout path: flush_o is high for exactly DrainMax cycles.
- Minimum sequence length, with isolated_i and outstanding_i already satisfied: 1 (ISOLATE) + 1 (DRAIN) + RstHoldCycles + 1 (RELEASE) cycles.

## Test plan
- Reset check: assert rst_ni low mid-RESET (slv_rst_no=0) -> all outputs return to reset values while rst_ni is low, with no clock edge needed; after release the FSM is in IDLE.
- Normal recovery: enable_i=1, timeout_i pulse, isolated_i rising 3 cycles later, outstanding_i going 2→0 over 5 DRAIN cycles -> flush_o high for 5 cycles, slv_rst_no low for 16 cycles, recover_cnt_o=1, irq_o=1, drain_fail_o=0.
- Drain deadline: DrainMax=8 and outstanding_i held at 1 -> flush_o high for exactly 8 cycles, drain_fail_o=1, RESET entered, sequence completes.
- Deadline tie: outstanding_i reaches 0 on the same cycle the counter hits DrainMax-1 -> drain_fail_o stays 0.
- Ignored events:
  - enable_i=0 with a timeout_i pulse -> state_o stays 0 and irq_o stays 0.
  - A second timeout_i during DRAIN -> recover_cnt_o increments by 1 only.
- IRQ priority: irq_clear_i asserted in the same cycle as a new timeout_i in IDLE -> irq_o=1; irq_clear_i alone afterwards -> irq_o=0 on the next cycle.
- Counter saturation: 256 back-to-back recoveries -> recover_cnt_o=255.

Source files
------------

// File: rtl/axi_mon_recovery_ctrl.sv
// rtl/axi_mon_recovery_ctrl.sv - timeout recovery sequencer: isolate, drain, reset, release the monitored slave
module axi_mon_recovery_ctrl #(
    parameter int unsigned MaxUniqIds    = 1,
    parameter int unsigned MaxTxnsPerId  = 2,
    parameter int unsigned CntWidth      = 10,
    parameter int unsigned DrainMax      = 1000,
    parameter int unsigned RstHoldCycles = 16,
    parameter int unsigned TxnCntWidth   = $clog2(MaxUniqIds * MaxTxnsPerId + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_i,
    input  logic                   timeout_i,
    input  logic                   isolated_i,
    input  logic [TxnCntWidth-1:0] outstanding_i,
    input  logic                   irq_clear_i,
    output logic                   isolate_o,
    output logic                   flush_o,
    output logic                   slv_rst_no,
    output logic                   irq_o,
    output logic                   drain_fail_o,
    output logic [7:0]             recover_cnt_o,
    output logic [2:0]             state_o
);

    localparam int unsigned HoldWidth = (RstHoldCycles > 1) ? $clog2(RstHoldCycles) : 1;
    localparam logic [CntWidth-1:0]  DrainLast = CntWidth'(DrainMax - 1);
    localparam logic [HoldWidth-1:0] HoldLoad  = HoldWidth'(RstHoldCycles - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISOLATE = 3'd1,
        DRAIN   = 3'd2,
        RESET   = 3'd3,
        RELEASE = 3'd4
    } state_e;

    state_e                state_q;
    logic [CntWidth-1:0]   drain_cnt_q;
    logic [HoldWidth-1:0]  hold_cnt_q;
    logic                  isolate_q;
    logic                  flush_q;
    logic                  slv_rst_nq;
    logic                  irq_q;
    logic                  drain_fail_q;
    logic [7:0]            recover_cnt_q;

    // Outputs are registered alongside the state so each one changes on the same edge as its state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            drain_cnt_q   <= '0;
            hold_cnt_q    <= '0;
            isolate_q     <= 1'b0;
            flush_q       <= 1'b0;
            slv_rst_nq    <= 1'b1;
            irq_q         <= 1'b0;
            drain_fail_q  <= 1'b0;
            recover_cnt_q <= '0;
        end else begin
            // Clear is overridden below when a new recovery starts in the same cycle.
            if (irq_clear_i) begin
                irq_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (enable_i && timeout_i) begin
                        state_q   <= ISOLATE;
                        isolate_q <= 1'b1;
                        irq_q     <= 1'b1;
                    end
                end
                ISOLATE: begin
                    if (isolated_i) begin
                        state_q     <= DRAIN;
                        flush_q     <= 1'b1;
                        drain_cnt_q <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q != {CntWidth{1'b1}}) begin
                        drain_cnt_q <= drain_cnt_q + CntWidth'(1);
                    end
                    if (outstanding_i == '0 || drain_cnt_q == DrainLast) begin
                        state_q    <= RESET;
                        flush_q    <= 1'b0;
                        slv_rst_nq <= 1'b0;
                        hold_cnt_q <= HoldLoad;
                        if (outstanding_i != '0) begin
                            drain_fail_q <= 1'b1;
                        end
                    end
                end
                RESET: begin
                    if (hold_cnt_q == '0) begin
                        state_q    <= RELEASE;
                        isolate_q  <= 1'b0;
                        slv_rst_nq <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - HoldWidth'(1);
                    end
                end
                RELEASE: begin
                    if (!isolated_i) begin
                        state_q <= IDLE;
                        if (recover_cnt_q != 8'hff) begin
                            recover_cnt_q <= recover_cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    isolate_q  <= 1'b0;
                    flush_q    <= 1'b0;
                    slv_rst_nq <= 1'b1;
                end
            endcase
        end
    end

    assign isolate_o     = isolate_q;
    assign flush_o       = flush_q;
    assign slv_rst_no    = slv_rst_nq;
    assign irq_o         = irq_q;
    assign drain_fail_o  = drain_fail_q;
    assign recover_cnt_o = recover_cnt_q;
    assign state_o       = (state_q > RELEASE) ? IDLE : state_q;

endmodule

// File: tb/tb_axi_mon_recovery_ctrl.sv
// tb/tb_axi_mon_recovery_ctrl.sv - directed scoreboard bench for axi_mon_recovery_ctrl
module tb_axi_mon_recovery_ctrl;

    localparam int DRAIN_MAX = 8;
    localparam int RST_HOLD  = 16;
    localparam int TXN_W     = 2;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic             enable_i, timeout_i, irq_clear_i;
    logic             iso_manual, gate_auto;
    logic             isolated_i;
    logic [TXN_W-1:0] outstanding_i;
    logic             isolate_o, flush_o, slv_rst_no, irq_o, drain_fail_o;
    logic [7:0]       recover_cnt_o;
    logic [2:0]       state_o;

    int n_cmp = 0;
    int n_err = 0;
    int model_cnt = 0;
    int exp_flush[$];
    int exp_rst[$];
    int exp_cnt[$];

    always #5 clk = ~clk;

    // Isolation gate model: in auto mode it follows the request with no delay.
    assign isolated_i = gate_auto ? isolate_o : iso_manual;

    axi_mon_recovery_ctrl #(
        .DrainMax      (DRAIN_MAX),
        .RstHoldCycles (RST_HOLD)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .enable_i      (enable_i),
        .timeout_i     (timeout_i),
        .isolated_i    (isolated_i),
        .outstanding_i (outstanding_i),
        .irq_clear_i   (irq_clear_i),
        .isolate_o     (isolate_o),
        .flush_o       (flush_o),
        .slv_rst_no    (slv_rst_no),
        .irq_o         (irq_o),
        .drain_fail_o  (drain_fail_o),
        .recover_cnt_o (recover_cnt_o),
        .state_o       (state_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic void push_cnt();
        if (model_cnt < 255) model_cnt++;
        exp_cnt.push_back(model_cnt);
    endfunction

    // Pulse-width and completion monitor: pops expectations when the DUT finishes a pulse or a recovery.
    initial begin
        int fl_run = 0;
        int rs_run = 0;
        logic [2:0] prev_state = 3'd0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                fl_run = 0;
                rs_run = 0;
                prev_state = 3'd0;
            end else begin
                if (flush_o) fl_run++;
                else if (fl_run > 0) begin
                    check("flush_pending", exp_flush.size() > 0, 1);
                    if (exp_flush.size() > 0) check("flush_len", fl_run, exp_flush.pop_front());
                    fl_run = 0;
                end
                if (!slv_rst_no) rs_run++;
                else if (rs_run > 0) begin
                    check("rst_pending", exp_rst.size() > 0, 1);
                    if (exp_rst.size() > 0) check("rst_len", rs_run, exp_rst.pop_front());
                    rs_run = 0;
                end
                if (prev_state == 3'd4 && state_o == 3'd0) begin
                    check("cnt_pending", exp_cnt.size() > 0, 1);
                    if (exp_cnt.size() > 0) check("recover_cnt", recover_cnt_o, exp_cnt.pop_front());
                end
                prev_state = state_o;
            end
        end
    end

    task automatic recover(input int iso_delay, input int zero_at, input bit extra_to);
        int k;
        int i;
        exp_flush.push_back((zero_at == 0) ? DRAIN_MAX : zero_at);
        exp_rst.push_back(RST_HOLD);
        push_cnt();
        gate_auto = 1'b0; iso_manual = 1'b0; enable_i = 1'b1; outstanding_i = 2'd2;
        timeout_i = 1'b1;
        tick();
        timeout_i = 1'b0;
        check("isolate_state", state_o, 1);
        check("isolate_o", isolate_o, 1);
        check("irq_on_entry", irq_o, 1);
        repeat (iso_delay - 1) tick();
        iso_manual = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
            if (extra_to) timeout_i = (k == 2);
            if (k == zero_at) outstanding_i = '0;
        end while (flush_o && k < 100);
        timeout_i = 1'b0;
        check("drain_exit", k < 100, 1);
        i = 0;
        while (state_o != 3'd4 && i < 100) begin tick(); i++; end
        check("release_reached", state_o, 4);
        iso_manual = 1'b0;
        tick();
        check("idle_return", state_o, 0);
        outstanding_i = '0;
    endtask

    task automatic auto_recover(input bit clr);
        int n;
        exp_flush.push_back(1);
        exp_rst.push_back(RST_HOLD);
        push_cnt();
        gate_auto = 1'b1; outstanding_i = '0; enable_i = 1'b1;
        irq_clear_i = clr;
        timeout_i = 1'b1;
        tick();
        timeout_i = 1'b0; irq_clear_i = 1'b0;
        check("auto_irq", irq_o, 1);
        n = 0;
        do begin n++; tick(); end while (state_o != 3'd0 && n < 100);
        check("min_seq_len", n, RST_HOLD + 3);
    endtask

    initial begin
        int i;
        rst_ni = 1'b0; enable_i = 1'b0; timeout_i = 1'b0; irq_clear_i = 1'b0;
        iso_manual = 1'b0; gate_auto = 1'b0; outstanding_i = '0;
        tick(); tick();
        check("rst_state", state_o, 0);
        check("rst_isolate", isolate_o, 0);
        check("rst_flush", flush_o, 0);
        check("rst_slv_rst_n", slv_rst_no, 1);
        check("rst_irq", irq_o, 0);
        check("rst_drain_fail", drain_fail_o, 0);
        check("rst_cnt", recover_cnt_o, 0);
        rst_ni = 1'b1;
        tick();

        // Asynchronous reset while the downstream reset is asserted
        exp_flush.push_back(1);
        gate_auto = 1'b1; enable_i = 1'b1; outstanding_i = '0;
        timeout_i = 1'b1;
        tick();
        timeout_i = 1'b0;
        i = 0;
        while (slv_rst_no && i < 20) begin tick(); i++; end
        check("reach_reset", slv_rst_no, 0);
        repeat (3) tick();
        #2 rst_ni = 1'b0;
        #1;
        check("async_state", state_o, 0);
        check("async_isolate", isolate_o, 0);
        check("async_flush", flush_o, 0);
        check("async_slv_rst_n", slv_rst_no, 1);
        check("async_irq", irq_o, 0);
        check("async_drain_fail", drain_fail_o, 0);
        check("async_cnt", recover_cnt_o, 0);
        tick(); tick();
        rst_ni = 1'b1;
        tick();
        check("post_rst_idle", state_o, 0);

        // Timeout with enable low is ignored
        gate_auto = 1'b0; enable_i = 1'b0;
        timeout_i = 1'b1;
        tick();
        timeout_i = 1'b0;
        check("dis_state", state_o, 0);
        check("dis_irq", irq_o, 0);
        tick();
        check("dis_state2", state_o, 0);

        recover(3, 5, 1'b0);
        check("norm_irq", irq_o, 1);
        check("norm_fail", drain_fail_o, 0);
        check("norm_cnt", recover_cnt_o, 1);

        recover(1, DRAIN_MAX, 1'b0);
        check("tie_fail", drain_fail_o, 0);

        recover(2, 5, 1'b1);
        tick();
        check("extra_to_idle", state_o, 0);
        check("extra_to_cnt", recover_cnt_o, 3);

        irq_clear_i = 1'b1;
        tick();
        irq_clear_i = 1'b0;
        check("irq_cleared", irq_o, 0);
        auto_recover(1'b1);
        irq_clear_i = 1'b1;
        tick();
        irq_clear_i = 1'b0;
        check("irq_clear_alone", irq_o, 0);

        recover(1, 0, 1'b0);
        check("deadline_fail", drain_fail_o, 1);

        for (int r = 0; r < 256; r++) auto_recover(1'b0);
        tick();
        check("cnt_saturated", recover_cnt_o, 255);
        check("fail_sticky", drain_fail_o, 1);
        check("flush_q_empty", exp_flush.size(), 0);
        check("rst_q_empty", exp_rst.size(), 0);
        check("cnt_q_empty", exp_cnt.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
